// File: rtl/multicycle_control_unit_if.sv
// Handshake and control bundle between the multi-cycle control FSM and the CPU datapath/memory.
// master = control unit; slave = datapath, memory or testbench side.
interface multicycle_control_unit_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned CNT_W    = 16
) ();

  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                zero;

  logic                reg_dst;
  logic                alu_src;
  logic                mem_to_reg;
  logic [ALUOP_W-1:0]  alu_op;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                pc_write;
  logic                reg_write;
  logic                branch;
  logic                branch_taken;
  logic                instr_done;
  logic                illegal_op;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  opcode, mem_ready, zero,
    output reg_dst, alu_src, mem_to_reg, alu_op, i_or_d, mem_read, mem_write, ir_write,
           pc_write, reg_write, branch, branch_taken, instr_done, illegal_op, instr_count
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  reg_dst, alu_src, mem_to_reg, alu_op, i_or_d, mem_read, mem_write, ir_write,
           pc_write, reg_write, branch, branch_taken, instr_done, illegal_op, instr_count
  );

endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller for the 16-bit CPU, with
// per-instruction latched datapath selects and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 2,
  parameter int unsigned CNT_W    = 16
) (
  input logic                       i_clk,
  input logic                       i_rst,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback
  } state_e;

  state_e           r_state;
  logic             r_reg_dst;
  logic             r_alu_src;
  logic             r_mem_to_reg;
  logic [1:0]       r_alu_op;
  logic             r_is_lw;
  logic             r_is_sw;
  logic             r_is_beq;
  logic [CNT_W-1:0] r_count;

  logic       w_upper_zero;
  logic       w_legal;
  logic       w_dst;
  logic       w_src;
  logic       w_m2r;
  logic [1:0] w_aluop;
  logic       w_lw;
  logic       w_sw;
  logic       w_beq;

  logic w_i_or_d;
  logic w_mem_read;
  logic w_mem_write;
  logic w_ir_write;
  logic w_pc_write;
  logic w_reg_write;
  logic w_branch;
  logic w_instr_done;
  logic w_illegal_op;
  logic w_retire;

  // Opcodes live in the low nibble; any set upper bit makes the opcode illegal.
  assign w_upper_zero = ((bus.opcode >> 4) == '0);

  always_comb begin
    w_legal = 1'b0;
    w_dst   = 1'b0;
    w_src   = 1'b0;
    w_m2r   = 1'b0;
    w_aluop = 2'b00;
    w_lw    = 1'b0;
    w_sw    = 1'b0;
    w_beq   = 1'b0;
    if (w_upper_zero) begin
      case (bus.opcode[3:0])
        4'b0000, 4'b0001, 4'b0010: begin
          w_legal = 1'b1;
          w_dst   = 1'b1;
          w_aluop = 2'b10;
        end
        4'b1001, 4'b1010, 4'b1011: begin
          w_legal = 1'b1;
          w_src   = 1'b1;
          w_aluop = 2'b11;
        end
        4'b1100: begin
          w_legal = 1'b1;
          w_src   = 1'b1;
          w_m2r   = 1'b1;
          w_lw    = 1'b1;
        end
        4'b1101: begin
          w_legal = 1'b1;
          w_src   = 1'b1;
          w_sw    = 1'b1;
        end
        4'b1111: begin
          w_legal = 1'b1;
          w_aluop = 2'b01;
          w_beq   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobes gated by reset so every output reads 0 the instant reset rises.
  always_comb begin
    w_i_or_d     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_branch     = 1'b0;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;
    if (!i_rst) begin
      unique case (r_state)
        StFetch: begin
          w_mem_read = 1'b1;
          w_ir_write = bus.mem_ready;
          w_pc_write = bus.mem_ready;
        end
        StDecode: begin
          w_illegal_op = ~w_legal;
          w_instr_done = ~w_legal;
        end
        StExecute: begin
          w_branch     = r_is_beq;
          w_instr_done = r_is_beq;
        end
        StMemory: begin
          w_i_or_d     = 1'b1;
          w_mem_read   = r_is_lw;
          w_mem_write  = r_is_sw;
          w_instr_done = r_is_sw & bus.mem_ready;
        end
        StWriteback: begin
          w_reg_write  = 1'b1;
          w_instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_retire = w_instr_done & ~w_illegal_op;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StFetch;
      r_reg_dst    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_op     <= 2'b00;
      r_is_lw      <= 1'b0;
      r_is_sw      <= 1'b0;
      r_is_beq     <= 1'b0;
      r_count      <= '0;
    end else begin
      unique case (r_state)
        StFetch: begin
          if (bus.mem_ready) r_state <= StDecode;
        end
        StDecode: begin
          if (w_legal) begin
            r_reg_dst    <= w_dst;
            r_alu_src    <= w_src;
            r_mem_to_reg <= w_m2r;
            r_alu_op     <= w_aluop;
            r_is_lw      <= w_lw;
            r_is_sw      <= w_sw;
            r_is_beq     <= w_beq;
            r_state      <= StExecute;
          end else begin
            r_state <= StFetch;
          end
        end
        StExecute: begin
          if (r_is_beq) r_state <= StFetch;
          else if (r_is_lw || r_is_sw) r_state <= StMemory;
          else r_state <= StWriteback;
        end
        StMemory: begin
          if (bus.mem_ready) r_state <= r_is_lw ? StWriteback : StFetch;
        end
        StWriteback: r_state <= StFetch;
        default:     r_state <= StFetch;
      endcase
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.reg_dst      = r_reg_dst;
  assign bus.alu_src      = r_alu_src;
  assign bus.mem_to_reg   = r_mem_to_reg;
  assign bus.alu_op       = ALUOP_W'(r_alu_op);
  assign bus.i_or_d       = w_i_or_d;
  assign bus.mem_read     = w_mem_read;
  assign bus.mem_write    = w_mem_write;
  assign bus.ir_write     = w_ir_write;
  assign bus.pc_write     = w_pc_write;
  assign bus.reg_write    = w_reg_write;
  assign bus.branch       = w_branch;
  assign bus.branch_taken = w_branch & bus.zero;
  assign bus.instr_done   = w_instr_done;
  assign bus.illegal_op   = w_illegal_op;
  assign bus.instr_count  = r_count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: opcode table, directed multi-cycle sequences and random instruction
// streams checked cycle by cycle against a per-instruction schedule model.
module tb_multicycle_control_unit;

  localparam int unsigned TB_CNT_W = 4;

  localparam logic [9:0] S_MR   = 10'h200;
  localparam logic [9:0] S_MW   = 10'h100;
  localparam logic [9:0] S_IOD  = 10'h080;
  localparam logic [9:0] S_IRW  = 10'h040;
  localparam logic [9:0] S_PCW  = 10'h020;
  localparam logic [9:0] S_RW   = 10'h010;
  localparam logic [9:0] S_BR   = 10'h008;
  localparam logic [9:0] S_BT   = 10'h004;
  localparam logic [9:0] S_DONE = 10'h002;
  localparam logic [9:0] S_ILL  = 10'h001;

  typedef struct {
    logic [3:0]  op;
    logic        legal;
    logic [4:0]  sel;     // {reg_dst, alu_src, mem_to_reg, alu_op}
    int          cycles;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  logic [4:0]          m_sel;
  logic [TB_CNT_W-1:0] m_count;
  vec_t                tbl[16];

  multicycle_control_unit_if #(.OPCODE_W(4), .ALUOP_W(2), .CNT_W(TB_CNT_W)) bus ();

  multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(2), .CNT_W(TB_CNT_W)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [9:0] strobes();
    return {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
            bus.reg_write, bus.branch, bus.branch_taken, bus.instr_done, bus.illegal_op};
  endfunction

  function automatic logic [4:0] sels();
    return {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.alu_op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance past the edge.
  task automatic step(input logic rdy, input logic z, input logic [3:0] op,
                      input logic [9:0] exp);
    bus.mem_ready = rdy;
    bus.zero      = z;
    bus.opcode    = op;
    @(negedge clk);
    check("strobes", strobes(), exp);
    check("selects", sels(), m_sel);
    check("count", bus.instr_count, m_count);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ref_sel(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2: return 5'b1_0_0_10;
      4'h9, 4'hA, 4'hB: return 5'b0_1_0_11;
      4'hC:             return 5'b0_1_1_00;
      4'hD:             return 5'b0_1_0_00;
      4'hF:             return 5'b0_0_0_01;
      default:          return m_sel;
    endcase
  endfunction

  // Expected per-cycle schedule of one instruction; opcode is garbage outside DECODE.
  task automatic run_instr(input logic [3:0] op, input int fs, input int ms, input logic z);
    logic is_lw, is_sw, is_beq, is_alu;
    logic [9:0] mem;
    is_lw  = (op == 4'hC);
    is_sw  = (op == 4'hD);
    is_beq = (op == 4'hF);
    is_alu = (op inside {4'h0, 4'h1, 4'h2, 4'h9, 4'hA, 4'hB});
    for (int k = 0; k < fs; k++) step(1'b0, rb(), rop(), S_MR);
    step(1'b1, rb(), rop(), S_MR | S_IRW | S_PCW);
    if (!(is_lw || is_sw || is_beq || is_alu)) begin
      step(rb(), rb(), op, S_DONE | S_ILL);
      return;
    end
    step(rb(), rb(), op, 10'h0);
    m_sel = ref_sel(op);
    if (is_beq) begin
      step(rb(), z, rop(), S_BR | (z ? S_BT : 10'h0) | S_DONE);
    end else if (is_alu) begin
      step(rb(), rb(), rop(), 10'h0);
      step(rb(), rb(), rop(), S_RW | S_DONE);
    end else begin
      step(rb(), rb(), rop(), 10'h0);
      mem = S_IOD | (is_lw ? S_MR : S_MW);
      for (int k = 0; k < ms; k++) step(1'b0, rb(), rop(), mem);
      step(1'b1, rb(), rop(), mem | (is_sw ? S_DONE : 10'h0));
      if (is_lw) step(rb(), rb(), rop(), S_RW | S_DONE);
    end
    m_count = m_count + 1'b1;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    m_sel   = 5'b0;
    m_count = '0;

    tbl[0]  = '{4'h0, 1'b1, 5'b10010, 4};
    tbl[1]  = '{4'h1, 1'b1, 5'b10010, 4};
    tbl[2]  = '{4'h2, 1'b1, 5'b10010, 4};
    tbl[3]  = '{4'h3, 1'b0, 5'b00000, 2};
    tbl[4]  = '{4'h4, 1'b0, 5'b00000, 2};
    tbl[5]  = '{4'h5, 1'b0, 5'b00000, 2};
    tbl[6]  = '{4'h6, 1'b0, 5'b00000, 2};
    tbl[7]  = '{4'h7, 1'b0, 5'b00000, 2};
    tbl[8]  = '{4'h8, 1'b0, 5'b00000, 2};
    tbl[9]  = '{4'h9, 1'b1, 5'b01011, 4};
    tbl[10] = '{4'hA, 1'b1, 5'b01011, 4};
    tbl[11] = '{4'hB, 1'b1, 5'b01011, 4};
    tbl[12] = '{4'hC, 1'b1, 5'b01100, 5};
    tbl[13] = '{4'hD, 1'b1, 5'b01000, 4};
    tbl[14] = '{4'hE, 1'b0, 5'b00000, 2};
    tbl[15] = '{4'hF, 1'b1, 5'b00001, 3};

    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    bus.opcode    = 4'h1;
    #2;
    check("reset_strobes", strobes(), 10'h0);
    check("reset_selects", sels(), 5'b0);
    check("reset_count", bus.instr_count, 0);
    @(posedge clk);
    #1;
    check("reset_hold_strobes", strobes(), 10'h0);
    rst = 1'b0;

    // ADD, then LW with two memory stalls, SW, BEQ taken/not taken, illegal 0101.
    run_instr(4'h1, 0, 0, 1'b0);
    check("count_after_add", bus.instr_count, 1);
    run_instr(4'hC, 0, 2, 1'b0);
    run_instr(4'hD, 0, 0, 1'b0);
    run_instr(4'hF, 0, 0, 1'b1);
    run_instr(4'hF, 0, 0, 1'b0);
    check("count_after_sw_beq", bus.instr_count, 5);
    run_instr(4'h5, 1, 0, 1'b0);
    check("count_after_illegal", bus.instr_count, 5);

    for (int i = 0; i < 16; i++) begin
      int   done_at;
      logic ill;
      done_at       = -1;
      ill           = 1'b0;
      bus.opcode    = tbl[i].op;
      bus.mem_ready = 1'b1;
      bus.zero      = 1'b0;
      for (int c = 0; c < 8 && done_at < 0; c++) begin
        @(negedge clk);
        ill = ill | bus.illegal_op;
        if (bus.instr_done) done_at = c;
        @(posedge clk);
        #1;
      end
      if (tbl[i].legal) begin
        m_sel   = tbl[i].sel;
        m_count = m_count + 1'b1;
      end
      check("tbl_cycles", 32'(done_at + 1), 32'(tbl[i].cycles));
      check("tbl_illegal", ill, !tbl[i].legal);
      check("tbl_selects", sels(), m_sel);
      check("tbl_count", bus.instr_count, m_count);
    end

    // Reset arriving mid-MEMORY of a SW must drop MemWrite at once.
    step(1'b1, 1'b0, 4'h0, S_MR | S_IRW | S_PCW);
    step(1'b1, 1'b0, 4'hD, 10'h0);
    m_sel = ref_sel(4'hD);
    step(1'b1, 1'b0, 4'h0, 10'h0);
    bus.mem_ready = 1'b0;
    #2;
    check("pre_reset_memwrite", strobes(), S_IOD | S_MW);
    rst = 1'b1;
    #1;
    m_sel   = 5'b0;
    m_count = '0;
    check("midreset_strobes", strobes(), 10'h0);
    check("midreset_selects", sels(), 5'b0);
    check("midreset_count", bus.instr_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(4'h9, 1, 0, 1'b0);

    // Counter wraps back to zero after 2^CNT_W retirements.
    for (int i = 0; i < 15; i++) run_instr(4'h9, 0, 0, 1'b0);
    check("wrap_count", bus.instr_count, 0);

    for (int i = 0; i < 150; i++) begin
      run_instr(rop(), $urandom_range(0, 2), $urandom_range(0, 2), rb());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
